mem_replace_arbiter: RTL

//  Shares mem_manager's single replace port (mem_replace_num/mem_replace_valid) between two requesters:
//  the host (UART replace-number messages) and the on-chip scrubber (test-pattern rewrite).

---
 rtl/mem_replace_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/mem_replace_arbiter.sv
// Round-robin arbiter sharing mem_manager's single replace port between the host and the scrubber.
// Issues one-cycle replace strobes followed by a fixed holdoff gap; same-address collisions drop the scrub request.
module mem_replace_arbiter #(
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run,
  input  logic                       host_valid,
  input  logic [ADDR_W+DATA_W-1:0]   host_num,
  output logic                       host_ready,
  input  logic                       scrub_valid,
  input  logic [ADDR_W+DATA_W-1:0]   scrub_num,
  output logic                       scrub_ready,
  output logic                       scrub_dropped,
  output logic [ADDR_W+DATA_W-1:0]   mem_replace_num,
  output logic                       mem_replace_valid,
  output logic                       busy,
  output logic [CNT_W-1:0]           issue_count
);

  localparam int unsigned PKT_W = ADDR_W + DATA_W;
  localparam int unsigned HW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLDOFF
  } state_t;

  state_t          state;
  logic [HW-1:0]   hold_cnt;
  logic            last_grant_host;
  logic            same_addr_c;
  logic            host_win_c;

  // Address field occupies the packet MSBs; a collision lets the host overwrite and discards the scrub.
  assign same_addr_c = host_valid && scrub_valid &&
                       (host_num[PKT_W-1 -: ADDR_W] == scrub_num[PKT_W-1 -: ADDR_W]);
  assign host_win_c  = host_valid && (!scrub_valid || same_addr_c || !last_grant_host);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      hold_cnt          <= '0;
      last_grant_host   <= 1'b0;
      host_ready        <= 1'b0;
      scrub_ready       <= 1'b0;
      scrub_dropped     <= 1'b0;
      mem_replace_num   <= '0;
      mem_replace_valid <= 1'b0;
      busy              <= 1'b0;
      issue_count       <= '0;
    end else begin
      mem_replace_valid <= 1'b0;
      host_ready        <= 1'b0;
      scrub_ready       <= 1'b0;
      scrub_dropped     <= 1'b0;
      case (state)
        IDLE: begin
          if (run && (host_valid || scrub_valid)) begin
            state             <= ISSUE;
            busy              <= 1'b1;
            mem_replace_valid <= 1'b1;
            host_ready        <= host_win_c;
            scrub_ready       <= !host_win_c || same_addr_c;
            scrub_dropped     <= same_addr_c;
            mem_replace_num   <= host_win_c ? host_num : scrub_num;
            last_grant_host   <= host_win_c;
            if (issue_count != '1) begin
              issue_count <= issue_count + CNT_W'(1);
            end
          end
        end
        ISSUE: begin
          if (GAP_CYCLES == 0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state    <= HOLDOFF;
            hold_cnt <= HW'(GAP_CYCLES - 1);
          end
        end
        HOLDOFF: begin
          if (hold_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
